// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
package arb_pkg;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;

  // IDLE : no grant outstanding, next request wins on the following edge
  // OWN  : one requester holds the resource, hold counter running
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector (up to 16 requesters); 0 for all-zero.
  function automatic int onehot2idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// Round-robin winner select: lowest set bit at or after (ptr+1) mod N, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_masked,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         winner,
  output logic                 any
);

  localparam int IDW = $clog2(N);

  logic [IDW:0] sh;
  logic [N-1:0] rot;
  logic [N-1:0] sel;

  // Rotate so (ptr+1) sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    sh     = {1'b0, ptr} + (IDW+1)'(1);
    rot    = N'({req_masked, req_masked} >> sh);
    sel    = rot & (~rot + N'(1));
    winner = N'(({sel, sel} << sh) >> N);
    any    = |req_masked;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant lock and bounded hold for one shared resource.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int IDW    = $clog2(N);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              grant_vld_q, grant_vld_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic              preempt_q, preempt_d;

  logic [N-1:0] others;
  logic         owner_req;
  logic [N-1:0] pick_req;
  logic [N-1:0] pick_win;
  logic         pick_any;

  // While owning, the current owner is excluded so it cannot win its own release/preempt.
  assign others    = req & ~grant_q;
  assign owner_req = |(req & grant_q);
  assign pick_req  = (state_q == OWN) ? others : req;

  rr_pick #(.N(N)) u_pick (
    .req_masked (pick_req),
    .ptr        (ptr_q),
    .winner     (pick_win),
    .any        (pick_any)
  );

  // Next-state, grant and hold-counter decision.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          ptr_d   = IDW'(onehot2idx(16'(pick_win)));
          hold_d  = HOLD_W'(1);
          state_d = OWN;
        end
      end
      OWN: begin
        if (owner_req) begin
          if (!(|others) || (hold_q != HOLD_MAX)) begin
            // Hold counter saturates; it only matters once someone else waits.
            if (hold_q != HOLD_MAX) hold_d = hold_q + HOLD_W'(1);
          end else begin
            grant_d   = pick_win;
            ptr_d     = IDW'(onehot2idx(16'(pick_win)));
            hold_d    = HOLD_W'(1);
            preempt_d = 1'b1;
          end
        end else if (pick_any) begin
          grant_d = pick_win;
          ptr_d   = IDW'(onehot2idx(16'(pick_win)));
          hold_d  = HOLD_W'(1);
        end else begin
          grant_d = '0;
          hold_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
    grant_vld_d = |grant_d;
    grant_id_d  = IDW'(onehot2idx(16'(grant_d)));
  end

  // State and registered outputs; pointer starts at N-1 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N - 1);
      hold_q      <= '0;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      grant_id_q  <= grant_id_d;
      preempt_q   <= preempt_d;
    end
  end

  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed scenarios plus random traffic
// against a behavioural round-robin model.
module tb_rr_lock_arbiter;

  localparam int N     = 4;
  localparam int MAXH  = 8;
  localparam int BOUND = (N - 1) * MAXH + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_id;
  logic         preempt;

  int n_vec;
  int n_err;

  // Reference model state
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_pre;

  int waitc  [N];
  int budget [N];

  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_search(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_hold  = 0;
    m_pre   = 0;
  endtask

  // One arbitration decision made from the request vector seen at the edge.
  task automatic model_edge(input logic [N-1:0] r);
    int w;
    logic [N-1:0] oth;
    m_pre = 0;
    if (m_owner < 0) begin
      w = rr_search(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = w; m_hold = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (r[m_owner]) begin
        if (oth == 0) m_hold = (m_hold < MAXH) ? m_hold + 1 : MAXH;
        else if (m_hold < MAXH) m_hold = m_hold + 1;
        else begin
          w = rr_search(oth, m_ptr);
          m_owner = w; m_ptr = w; m_hold = 1; m_pre = 1;
        end
      end else begin
        w = rr_search(oth, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_ptr = w; m_hold = 1;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    chk("grant", 32'(grant), 32'(eg));
    chk("grant_vld", 32'(grant_vld), 32'(m_owner >= 0));
    chk("grant_id", 32'(grant_id), 32'((m_owner < 0) ? 0 : m_owner));
    chk("preempt", 32'(preempt), 32'(m_pre));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int prev_owner;
    logic [N-1:0] rn;
    bit over;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("reset_grant", 32'(grant), 32'(0));
    chk("reset_preempt", 32'(preempt), 32'(0));
    rst = 1'b0;

    // Async reset in the middle of a grant
    req = 4'b0010;
    step();
    chk("mid_pre_grant", 32'(grant), 32'(4'b0010));
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_model();
    chk("mid_rst_grant", 32'(grant), 32'(0));
    chk("mid_rst_preempt", 32'(preempt), 32'(0));
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All request, each drops after one grant cycle: back-to-back rotation
    req = 4'b1111; step(); chk("rot0", 32'(grant), 32'(4'b0001));
    req = 4'b1110; step(); chk("rot1", 32'(grant), 32'(4'b0010));
    req = 4'b1100; step(); chk("rot2", 32'(grant), 32'(4'b0100));
    req = 4'b1000; step(); chk("rot3", 32'(grant), 32'(4'b1000));
    req = 4'b0000; step(); chk("rot_idle", 32'(grant), 32'(0));

    // Lone requester holds indefinitely, never preempted
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("solo_grant", 32'(grant), 32'(4'b0001));
      chk("solo_preempt", 32'(preempt), 32'(0));
    end
    req = '0;
    step();

    // Two contenders: MAX_HOLD cycles each, preempt pulse at each handover
    do_reset();
    req = 4'b0011;
    for (int k = 1; k <= 2 * MAXH + 1; k++) begin
      step();
      if (k <= MAXH) begin
        chk("pair_a", 32'(grant), 32'(4'b0001));
        chk("pair_a_pre", 32'(preempt), 32'(0));
      end else if (k <= 2 * MAXH) begin
        chk("pair_b", 32'(grant), 32'(4'b0010));
        chk("pair_b_pre", 32'(preempt), 32'(k == MAXH + 1));
      end else begin
        chk("pair_c", 32'(grant), 32'(4'b0001));
        chk("pair_c_pre", 32'(preempt), 32'(1));
      end
    end
    req = '0;
    step();

    // Release with search starting past the released owner
    req = 4'b0100; step(); chk("wrap_own", 32'(grant), 32'(4'b0100));
    req = 4'b1001; step(); chk("wrap_next", 32'(grant), 32'(4'b1000));
    req = 4'b0001; step(); chk("wrap_last", 32'(grant), 32'(4'b0001));
    req = '0;      step();

    // Random traffic: requesters hold until granted, keep it for a random length
    do_reset();
    for (int i = 0; i < N; i++) begin
      waitc[i]  = 0;
      budget[i] = 0;
    end
    prev_owner = -1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rn = req;
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) rn[i] = 1'b1;
        end else if (m_owner == i) begin
          if (budget[i] <= 1) rn[i] = 1'b0;
          else budget[i] = budget[i] - 1;
        end else if ($urandom_range(0, 31) == 0) begin
          rn[i] = 1'b0;
        end
      end
      req = rn;
      step();
      if (m_owner >= 0 && m_owner != prev_owner) budget[m_owner] = $urandom_range(1, 12);
      prev_owner = m_owner;
      chk("onehot0", 32'($onehot0(grant)), 32'(1));
      chk("grant_has_req", 32'((grant & ~req) == 0), 32'(1));
      over = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && !grant[i]) waitc[i] = waitc[i] + 1;
        else waitc[i] = 0;
        if (waitc[i] > BOUND) over = 1;
      end
      chk("wait_bound", 32'(over), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
